// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared types, AXI constants and address-split width helpers for icache_sa
package icache_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOOKUP,
      S_AR,
      S_REFILL,
      S_RESP
   } state_t;

   localparam logic [2:0] ARSIZE_WORD  = 3'b010;
   localparam logic [1:0] ARBURST_INCR = 2'b01;
   localparam logic [1:0] RESP_OKAY    = 2'b00;

   function automatic int off_w(input int line_words);
      return $clog2(line_words);
   endfunction

   function automatic int idx_w(input int sets);
      return $clog2(sets);
   endfunction

   function automatic int tag_w(input int sets, input int line_words);
      return 32 - $clog2(sets) - $clog2(line_words) - 2;
   endfunction

   // A direct-mapped build still needs a one-bit way field.
   function automatic int way_w(input int ways);
      return (ways > 1) ? $clog2(ways) : 1;
   endfunction

endpackage

// File: rtl/icache_victim.sv
// rtl/icache_victim.sv - victim way selection: lowest invalid way, else per-set round-robin
module icache_victim
   import icache_pkg::*;
#(
   parameter int WAYS = 2,
   parameter int SETS = 8,
   localparam int WW = way_w(WAYS),
   localparam int IW = idx_w(SETS)
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [IW-1:0]   set_i,
   input  logic [WAYS-1:0] valid_i,
   input  logic            update_i,
   output logic [WW-1:0]   victim_o
);

   logic [WW-1:0] rr_q [SETS];
   logic          any_inv;
   logic [WW-1:0] inv_way;

   // Descending scan so the lowest-index invalid way is the one left standing.
   always_comb begin
      any_inv = 1'b0;
      inv_way = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!valid_i[w]) begin
            any_inv = 1'b1;
            inv_way = WW'(w);
         end
      end
   end

   assign victim_o = any_inv ? inv_way : rr_q[set_i];

   always_ff @(posedge clock) begin
      if (!reset) begin
         for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
      end else if (update_i && !any_inv) begin
         rr_q[set_i] <= (rr_q[set_i] == WW'(WAYS - 1)) ? '0 : rr_q[set_i] + 1'b1;
      end
   end

endmodule

// File: rtl/icache_sa.sv
// rtl/icache_sa.sv - set-associative instruction cache with single-burst AXI4 line refill
// Define ICACHE_PERF_EN to add saturating hit/miss/error counters.
module icache_sa
   import icache_pkg::*;
#(
   parameter int WAYS       = 2,
   parameter int SETS       = 8,
   parameter int LINE_WORDS = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_pc,
   input  logic        fencei,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_inst,
   output logic        resp_err,
`ifdef ICACHE_PERF_EN
   output logic [31:0] hit_cnt,
   output logic [31:0] miss_cnt,
   output logic [31:0] err_cnt,
`endif
   output logic        arvalid,
   input  logic        arready,
   output logic [31:0] araddr,
   output logic [7:0]  arlen,
   output logic [2:0]  arsize,
   output logic [1:0]  arburst,
   input  logic        rvalid,
   output logic        rready,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rlast
);

   localparam int OFF = off_w(LINE_WORDS);
   localparam int IW  = idx_w(SETS);
   localparam int TW  = tag_w(SETS, LINE_WORDS);
   localparam int WW  = way_w(WAYS);
   localparam int BW  = OFF + 1;

   state_t          state_q;
   logic [31:2]     pc_q;
   logic [WAYS-1:0] valid_q [SETS];
   logic [TW-1:0]   tag_q   [SETS][WAYS];
   logic [31:0]     data_q  [SETS][WAYS][LINE_WORDS];
   logic [WW-1:0]   victim_q;
   logic [BW-1:0]   beat_q;
   logic            err_q;
   logic            fence_pending_q;
   logic            arvalid_q;
   logic            resp_valid_q;
   logic            resp_err_q;
   logic [31:0]     word_q;
   logic [31:0]     resp_inst_q;

   logic [TW-1:0]  pc_tag;
   logic [IW-1:0]  pc_idx;
   logic [OFF-1:0] pc_off;
   logic           hit;
   logic [WW-1:0]  hit_way;
   logic           lookup_miss;
   logic [WW-1:0]  victim;
   logic           beat_hs;
   logic           beat_is_off;
   logic           beat_err;
   logic           fill_ok;
   logic           unused_pc;

   assign pc_tag = pc_q[31:OFF+IW+2];
   assign pc_idx = pc_q[OFF+IW+1:OFF+2];
   assign pc_off = pc_q[OFF+1:2];
   assign unused_pc = ^req_pc[1:0];

   always_comb begin
      hit     = 1'b0;
      hit_way = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (valid_q[pc_idx][w] && (tag_q[pc_idx][w] == pc_tag)) begin
            hit     = 1'b1;
            hit_way = WW'(w);
         end
      end
   end

   assign lookup_miss = (state_q == S_LOOKUP) && !hit;

   icache_victim #(
      .WAYS (WAYS),
      .SETS (SETS)
   ) u_victim (
      .clock    (clock),
      .reset    (reset),
      .set_i    (pc_idx),
      .valid_i  (valid_q[pc_idx]),
      .update_i (lookup_miss),
      .victim_o (victim)
   );

   // beat_q saturates at LINE_WORDS so an overlong burst is caught at rlast.
   assign beat_hs     = (state_q == S_REFILL) && rvalid;
   assign beat_is_off = (beat_q == {1'b0, pc_off});
   assign beat_err    = err_q || (rresp != RESP_OKAY) || (beat_q != BW'(LINE_WORDS - 1));
   assign fill_ok     = !beat_err && !fence_pending_q;

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q         <= S_IDLE;
         for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
         pc_q            <= '0;
         victim_q        <= '0;
         beat_q          <= '0;
         err_q           <= 1'b0;
         fence_pending_q <= 1'b0;
         arvalid_q       <= 1'b0;
         resp_valid_q    <= 1'b0;
         resp_err_q      <= 1'b0;
         word_q          <= '0;
         resp_inst_q     <= '0;
      end else begin
         if (fencei && (state_q != S_IDLE)) fence_pending_q <= 1'b1;
         unique case (state_q)
            S_IDLE: begin
               // A fence outranks a request arriving in the same cycle.
               if (fencei || fence_pending_q) begin
                  for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
                  fence_pending_q <= 1'b0;
               end else if (req_valid) begin
                  pc_q    <= req_pc[31:2];
                  state_q <= S_LOOKUP;
               end
            end
            S_LOOKUP: begin
               if (hit) begin
                  resp_inst_q  <= data_q[pc_idx][hit_way][pc_off];
                  resp_err_q   <= 1'b0;
                  resp_valid_q <= 1'b1;
                  state_q      <= S_RESP;
               end else begin
                  victim_q                <= victim;
                  valid_q[pc_idx][victim] <= 1'b0;
                  arvalid_q               <= 1'b1;
                  beat_q                  <= '0;
                  err_q                   <= 1'b0;
                  state_q                 <= S_AR;
               end
            end
            S_AR: begin
               if (arready) begin
                  arvalid_q <= 1'b0;
                  state_q   <= S_REFILL;
               end
            end
            S_REFILL: begin
               if (rvalid) begin
                  if (rresp != RESP_OKAY) err_q <= 1'b1;
                  if (beat_is_off) word_q <= rdata;
                  if (!beat_q[OFF]) beat_q <= beat_q + 1'b1;
                  if (rlast) begin
                     if (fill_ok) valid_q[pc_idx][victim_q] <= 1'b1;
                     resp_inst_q  <= beat_is_off ? rdata : word_q;
                     resp_err_q   <= beat_err;
                     resp_valid_q <= 1'b1;
                     state_q      <= S_RESP;
                  end
               end
            end
            S_RESP: begin
               if (resp_ready) begin
                  resp_valid_q <= 1'b0;
                  resp_err_q   <= 1'b0;
                  state_q      <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Tag and data arrays carry no reset; the valid bits gate them.
   always_ff @(posedge clock) begin
      if (lookup_miss) tag_q[pc_idx][victim] <= pc_tag;
      if (beat_hs && !beat_q[OFF]) data_q[pc_idx][victim_q][beat_q[OFF-1:0]] <= rdata;
   end

`ifdef ICACHE_PERF_EN
   logic [31:0] hit_cnt_q;
   logic [31:0] miss_cnt_q;
   logic [31:0] err_cnt_q;

   always_ff @(posedge clock) begin
      if (!reset) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
         err_cnt_q  <= '0;
      end else begin
         if ((state_q == S_LOOKUP) && hit && (hit_cnt_q != '1)) hit_cnt_q <= hit_cnt_q + 32'd1;
         if (lookup_miss && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + 32'd1;
         if (beat_hs && rlast && beat_err && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + 32'd1;
      end
   end

   assign hit_cnt  = hit_cnt_q;
   assign miss_cnt = miss_cnt_q;
   assign err_cnt  = err_cnt_q;
`endif

   assign req_ready  = (state_q == S_IDLE) && !fence_pending_q;
   assign rready     = (state_q == S_REFILL);
   assign resp_valid = resp_valid_q;
   assign resp_inst  = resp_inst_q;
   assign resp_err   = resp_err_q;
   assign arvalid    = arvalid_q;
   assign araddr     = {pc_q[31:OFF+2], {(OFF + 2){1'b0}}};
   assign arlen      = 8'(LINE_WORDS - 1);
   assign arsize     = ARSIZE_WORD;
   assign arburst    = ARBURST_INCR;

endmodule

// File: doc/icache_sa.md
Name: icache_sa

Overview:
- Parametrised set-associative instruction cache; successor to the direct-mapped fetch cache.
- Sits between the IFU and the AXI4 read channel of the memory crossbar.
- Refills whole lines with one INCR burst.
- Adds valid/ready on both fetch sides, N-way replacement, bus-error reporting and safe fence.i during refill.

Parameters:
- WAYS, 2, associativity; power of two, 1..8.
- SETS, 8, number of sets; power of two, >=2.
- LINE_WORDS, 4, 32-bit words per line; power of two, 2..16.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low reset (asserted when 0)
- req_valid  in  1  fetch request
- req_ready  out  1  cache can accept a request
- req_pc  in  32  fetch address, word aligned
- fencei  in  1  one-cycle pulse: invalidate all lines
- resp_valid  out  1  instruction available
- resp_ready  in  1  IFU consumes response
- resp_inst  out  32  instruction word
- resp_err  out  1  refill returned non-OKAY rresp, or a burst-length error
- arvalid  out  1  AXI AR valid
- arready  in  1  AXI AR ready
- araddr  out  32  line-aligned address
- arlen  out  8  constant LINE_WORDS-1
- arsize  out  3  constant 3'b010
- arburst  out  2  constant 2'b01 (INCR)
- rvalid  in  1  AXI R valid
- rready  out  1  AXI R ready
- rdata  in  32  AXI R data
- rresp  in  2  AXI R response
- rlast  in  1  AXI R last

Behaviour:
- Address split:
  - offset = pc[OFF+1:2], where OFF = log2(LINE_WORDS).
  - index = next log2(SETS) bits.
  - tag = the remaining upper bits.
- States: IDLE, LOOKUP, AR, REFILL, RESP.
- Reset (reset==0):
  - state IDLE; all valid bits 0; all round-robin pointers 0.
  - arvalid, resp_valid, resp_err = 0; beat counter 0; fence_pending 0.
- Reset mid-refill: abandons the burst immediately. The bus is reset together with the cache; no drain is performed.
- Outputs:
  - req_ready = (state==IDLE) && !fence_pending.
  - rready = (state==REFILL).
- IDLE:
  - On req_valid && req_ready, latch pc and go to LOOKUP.
- LOOKUP (one cycle): compare the tags of all ways in parallel.
  - Hit: register the word and go to RESP. resp_valid rises 2 cycles after the accepting edge.
  - Miss:
    - Victim is the lowest-index invalid way if any exists; otherwise the set's round-robin pointer.
    - The pointer advances (mod WAYS) only when it was used.
    - Go to AR with arvalid=1 and araddr = {pc[31:OFF+2], zeros}.
- AR:
  - Hold arvalid and araddr stable until arready, then go to REFILL.
- REFILL:
  - Each rvalid beat writes rdata to word[beat] of the victim; beat increments.
  - The requested word is captured when beat==offset.
  - Any rresp!=0 sets a sticky err flag.
  - On the rlast beat, the line is marked valid with the new tag only if all of these hold: err clear, beat==LINE_WORDS-1, no fence pending.
  - Otherwise the victim stays invalid and resp_err=1 is returned.
  - rlast arriving early or late is an error.
  - Go to RESP.
- RESP:
  - resp_valid=1; resp_inst and resp_err are held stable until resp_ready.
  - On the handshake: resp_valid=0, state IDLE.
  - resp_err clears when the handshake completes.
- fencei:
  - In IDLE it clears all valid bits on the next edge.
  - In any other state it sets fence_pending. The pending invalidate is applied on the cycle the FSM re-enters IDLE, and fence_pending then clears.
  - The in-flight response is still delivered.
  - Both a fence pulse and a req in the same IDLE cycle: the fence wins; req is not accepted that cycle.
- Back-to-back hits: 3 cycles per fetch, assuming resp_ready is held high.

Optional Feature:
- Macro ICACHE_PERF_EN. When defined, adds these ports:
  - hit_cnt out 32
  - miss_cnt out 32
  - err_cnt out 32
- Counter behaviour:
  - Counters increment once per LOOKUP hit, once per LOOKUP miss, and once per error response.
  - They saturate at 32'hFFFF_FFFF and clear on reset only.
- When undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- icache_pkg contains:
  - state enum;
  - AXI constants (ARSIZE_WORD=3'b010, ARBURST_INCR=2'b01, RESP_OKAY=2'b00);
  - functions computing the tag, index and offset widths from the parameters.
- Sub-module icache_victim: per-set round-robin pointers plus the invalid-way priority encoder.
  - Inputs: set index, valid vector, update strobe.
  - Output: victim way.

Test Plan (WAYS=2, SETS=4, LINE_WORDS=4):
- Cold fetch of 0x8000_0008 with memory word=addr:
  - araddr=0x8000_0000, arlen=3, burst of 4 beats.
  - resp_inst=0x8000_0008, resp_err=0.
  - A re-fetch of 0x8000_000C hits with no AR; resp_valid is seen 2 cycles after acceptance.
- Conflict eviction:
  - Fill 0x8000_0000 and 0x8000_0040 (same set) in both ways.
  - Fetch 0x8000_0080: evicts way0.
  - Fetch 0x8000_0040: still a hit.
  - Fetch 0x8000_00C0: evicts way1.
- Refill with rresp=2'b10 on beat 2:
  - resp_err=1.
  - A re-fetch of the same address misses again (line not valid).
- fencei pulsed during REFILL:
  - The response is delivered and req_ready stays 0 until the invalidate applies.
  - A later fetch of the same line misses.
- Backpressure: hold resp_ready=0 for 5 cycles in RESP.
  - resp_valid and resp_inst stay stable; req_ready=0 throughout.
- Reset driven to 0 while in REFILL after beat 1:
  - arvalid=0 and resp_valid=0 next cycle.
  - After release, a fetch of the prior line misses.
